// File: rtl/de_pkg.sv
// de_pkg: shared types and default widths for the drawing-engine arbiter.
// Imported by de_arb_pick and de_arbiter.
package de_pkg;

    typedef enum logic {
        DE_IDLE  = 1'b0,
        DE_GRANT = 1'b1
    } de_state_e;

    localparam int DE_ADDR_W  = 18;
    localparam int DE_DATA_W  = 32;
    localparam int DE_NBYTE_W = 4;

endpackage

// File: rtl/de_arb_pick.sv
// de_arb_pick: combinational winner select for two requesters.
// DE_ARB_FIXED_PRIO_EN selects fixed priority (port 0) instead of round-robin.
module de_arb_pick
    import de_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_served,
    output logic win
);

`ifdef DE_ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = last_served;
    assign win = ~req0 & req1;
`else
    // On contention the port that was not served last goes next.
    assign win = (req0 & req1) ? ~last_served : req1;
`endif

endmodule

// File: rtl/de_arbiter.sv
// de_arbiter: two-port arbiter in front of the drawing-engine memory port.
// Build option DE_ARB_FIXED_PRIO_EN: port 0 always wins contention.
module de_arbiter
    import de_pkg::*;
#(
    parameter int ADDR_W = DE_ADDR_W,
    parameter int DATA_W = DE_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  req1,
    output logic                  ack0,
    output logic                  ack1,
    input  logic [ADDR_W-1:0]     addr0,
    input  logic [ADDR_W-1:0]     addr1,
    input  logic [DE_NBYTE_W-1:0] nbyte0,
    input  logic [DE_NBYTE_W-1:0] nbyte1,
    input  logic                  rnw0,
    input  logic                  rnw1,
    input  logic [DATA_W-1:0]     wdata0,
    input  logic [DATA_W-1:0]     wdata1,
    output logic [DATA_W-1:0]     rdata,
    output logic                  de_req,
    input  logic                  de_ack,
    output logic [ADDR_W-1:0]     de_addr,
    output logic [DE_NBYTE_W-1:0] de_nbyte,
    output logic                  de_rnw,
    output logic [DATA_W-1:0]     de_w_data,
    input  logic [DATA_W-1:0]     de_r_data,
    output logic                  busy,
    output logic                  owner
);

    de_state_e state;
    de_state_e state_nxt;

    logic owner_q;
    logic last_q;
    logic win;
    logic start;
    logic done;

    logic [ADDR_W-1:0]     addr_q;
    logic [DE_NBYTE_W-1:0] nbyte_q;
    logic                  rnw_q;
    logic [DATA_W-1:0]     wdata_q;

    de_arb_pick u_pick (
        .req0        (req0),
        .req1        (req1),
        .last_served (last_q),
        .win         (win)
    );

    assign start = (state == DE_IDLE) && (req0 || req1);
    assign done  = (state == DE_GRANT) && de_ack;

    always_comb begin
        state_nxt = state;
        unique case (state)
            DE_IDLE:  if (start) state_nxt = DE_GRANT;
            DE_GRANT: if (done)  state_nxt = DE_IDLE;
            default:  state_nxt = DE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= DE_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            addr_q  <= '0;
            nbyte_q <= '0;
            rnw_q   <= 1'b1;
            wdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (start) begin
                owner_q <= win;
                addr_q  <= win ? addr1  : addr0;
                nbyte_q <= win ? nbyte1 : nbyte0;
                rnw_q   <= win ? rnw1   : rnw0;
                wdata_q <= win ? wdata1 : wdata0;
            end
            if (done) last_q <= owner_q;
        end
    end

    // A completion arriving in the reset cycle belongs to an aborted transfer.
    assign ack0 = done & rst_n & ~owner_q;
    assign ack1 = done & rst_n &  owner_q;

    assign rdata     = de_r_data;
    assign busy      = (state == DE_GRANT);
    assign de_req    = busy;
    assign owner     = owner_q;
    assign de_addr   = addr_q;
    assign de_nbyte  = nbyte_q;
    assign de_rnw    = rnw_q;
    assign de_w_data = wdata_q;

endmodule

// File: tb/tb_de_arbiter.sv
// tb_de_arbiter: vector table, directed corner cases and a randomized
// transaction-level scoreboard for de_arbiter.
`timescale 1ns/1ps
module tb_de_arbiter;
    import de_pkg::*;

    localparam int AW = DE_ADDR_W;
    localparam int DW = DE_DATA_W;
    localparam int NW = DE_NBYTE_W;

`ifdef DE_ARB_FIXED_PRIO_EN
    localparam bit FIX = 1'b1;
`else
    localparam bit FIX = 1'b0;
`endif
    localparam logic P1 = FIX ? 1'b0 : 1'b1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rq [2];
    logic [AW-1:0] ra [2];
    logic [NW-1:0] rn [2];
    logic          rr [2];
    logic [DW-1:0] rw [2];
    logic          ack0, ack1;
    logic [DW-1:0] rdata;
    logic          de_req, de_ack;
    logic [AW-1:0] de_addr;
    logic [NW-1:0] de_nbyte;
    logic          de_rnw;
    logic [DW-1:0] de_w_data, de_r_data;
    logic          busy, owner;

    always #5 clk = ~clk;

    de_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0(rq[0]), .req1(rq[1]),
        .ack0(ack0), .ack1(ack1),
        .addr0(ra[0]), .addr1(ra[1]),
        .nbyte0(rn[0]), .nbyte1(rn[1]),
        .rnw0(rr[0]), .rnw1(rr[1]),
        .wdata0(rw[0]), .wdata1(rw[1]),
        .rdata(rdata),
        .de_req(de_req), .de_ack(de_ack),
        .de_addr(de_addr), .de_nbyte(de_nbyte),
        .de_rnw(de_rnw), .de_w_data(de_w_data),
        .de_r_data(de_r_data),
        .busy(busy), .owner(owner)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic r0, r1, dack;
        logic busy, own, a0, a1;
    } vec_t;

    vec_t tbl [9];

    // behavioural model state for the random phase
    logic          m_busy, m_own, m_last, m_prev_ack, dack;
    logic          pend [2];
    logic          hold [2];
    logic [AW-1:0] m_addr;
    logic [NW-1:0] m_nb;
    logic          m_rnw;
    logic [DW-1:0] m_wd, rd;
    int            lat, cnt, n_xfer, acks;

    initial begin
        for (int p = 0; p < 2; p++) begin
            rq[p] = 0; ra[p] = '0; rn[p] = '0; rr[p] = 0; rw[p] = '0;
        end
        de_ack = 0;
        de_r_data = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        chk("rst_de_req", de_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        chk("rst_ack0", ack0, 0);
        chk("rst_ack1", ack1, 0);
        chk("rst_addr", de_addr, 0);
        chk("rst_nbyte", de_nbyte, 0);
        chk("rst_rnw", de_rnw, 1);
        chk("rst_wdata", de_w_data, 0);

        // contention table: both ports held high, 1-cycle memory
        tbl[0] = '{1, 1, 0, 0, 0, 0, 0};
        tbl[1] = '{1, 1, 1, 1, 0, 1, 0};
        tbl[2] = '{1, 1, 0, 0, 0, 0, 0};
        tbl[3] = '{1, 1, 1, 1, P1, !P1, P1};
        tbl[4] = '{1, 1, 0, 0, 0, 0, 0};
        tbl[5] = '{1, 1, 1, 1, 0, 1, 0};
        tbl[6] = '{1, 1, 0, 0, 0, 0, 0};
        tbl[7] = '{1, 1, 1, 1, P1, !P1, P1};
        tbl[8] = '{0, 0, 0, 0, 0, 0, 0};
        ra[0] = 18'h00011;
        ra[1] = 18'h00022;
        for (int i = 0; i < 9; i++) begin
            rq[0] = tbl[i].r0;
            rq[1] = tbl[i].r1;
            de_ack = tbl[i].dack;
            #1;
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
            chk($sformatf("tbl%0d_ack0", i), ack0, tbl[i].a0);
            chk($sformatf("tbl%0d_ack1", i), ack1, tbl[i].a1);
            if (tbl[i].busy) begin
                chk($sformatf("tbl%0d_owner", i), owner, tbl[i].own);
                chk($sformatf("tbl%0d_addr", i), de_addr,
                    tbl[i].own ? ra[1] : ra[0]);
            end
            step();
        end
        de_ack = 0;

        // single read, memory answers 3 cycles after de_req rises
        ra[0] = 18'h00100; rn[0] = 4'hF; rr[0] = 1; rw[0] = '0;
        rq[0] = 1;
        step();
        chk("rd_de_req", de_req, 1);
        chk("rd_addr", de_addr, 18'h00100);
        chk("rd_rnw", de_rnw, 1);
        chk("rd_owner", owner, 0);
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            acks += int'(ack0);
            step();
        end
        de_ack = 1;
        de_r_data = 32'hDEADBEEF;
        #1;
        chk("rd_ack0", ack0, 1);
        chk("rd_ack1", ack1, 0);
        chk("rd_rdata", rdata, 32'hDEADBEEF);
        step();
        de_ack = 0;
        rq[0] = 0;
        #1;
        acks += int'(ack0);
        chk("rd_idle", busy, 0);
        chk("rd_extra_acks", acks, 0);

        // command hold on a port-1 write
        step();
        ra[1] = 18'h0002A; rn[1] = 4'hF; rr[1] = 0; rw[1] = 32'h12345678;
        rq[1] = 1;
        step();
        chk("wr_owner", owner, 1);
        chk("wr_rnw", de_rnw, 0);
        chk("wr_nbyte", de_nbyte, 4'hF);
        chk("wr_wdata0", de_w_data, 32'h12345678);
        rw[1] = '0;
        step();
        chk("wr_wdata1", de_w_data, 32'h12345678);
        de_ack = 1;
        #1;
        chk("wr_ack1", ack1, 1);
        chk("wr_wdata2", de_w_data, 32'h12345678);
        step();
        de_ack = 0;
        rq[1] = 0;

        // stray completion while idle
        step();
        de_ack = 1;
        #1;
        chk("stray_ack0", ack0, 0);
        chk("stray_ack1", ack1, 0);
        step();
        de_ack = 0;
        #1;
        chk("stray_busy", busy, 0);

        // req1 pulses while port 0 owns the bus
        ra[0] = 18'h00300; rr[0] = 0; rw[0] = 32'hA5A5A5A5;
        rq[0] = 1;
        step();
        acks = 0;
        rq[1] = 1;
        step();
        rq[1] = 0;
        chk("wd_owner", owner, 0);
        step();
        de_ack = 1;
        #1;
        acks += int'(ack1);
        chk("wd_ack0", ack0, 1);
        step();
        de_ack = 0;
        rq[0] = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            acks += int'(ack1);
            chk($sformatf("wd_busy%0d", i), busy, 0);
            step();
        end
        chk("wd_ack1_cnt", acks, 0);

        // reset in the middle of a port-1 transfer
        ra[1] = 18'h00400; rr[1] = 1;
        rq[1] = 1;
        step();
        chk("rm_busy0", busy, 1);
        chk("rm_owner0", owner, 1);
        rst_n = 0;
        de_ack = 1;
        #1;
        chk("rm_ack1", ack1, 0);
        step();
        rst_n = 1;
        de_ack = 0;
        rq[0] = 1;
        rq[1] = 1;
        #1;
        chk("rm_de_req", de_req, 0);
        chk("rm_busy1", busy, 0);
        step();
        chk("rm_busy2", busy, 1);
        chk("rm_owner2", owner, 0);
        de_ack = 1;
        #1;
        chk("rm_ack0", ack0, 1);
        step();
        de_ack = 0;
        rq[0] = 0;
        rq[1] = 0;

        // randomized traffic against the transaction-level model
        rst_n = 0;
        step();
        rst_n = 1;
        m_busy = 0; m_own = 0; m_last = 1; m_prev_ack = 0;
        m_addr = '0; m_nb = '0; m_rnw = 0; m_wd = '0;
        lat = 0; cnt = 0; n_xfer = 0;
        for (int p = 0; p < 2; p++) begin
            pend[p] = 0;
            hold[p] = 0;
        end
        for (int c = 0; c < 1500; c++) begin
            step();
            if (m_busy) begin
                if (m_prev_ack) begin
                    m_busy = 0;
                    m_last = m_own;
                end
            end else if (rq[0] | rq[1]) begin
                m_busy = 1;
                m_own = (rq[0] & rq[1]) ? (FIX ? 1'b0 : ~m_last) : rq[1];
                m_addr = ra[m_own];
                m_nb = rn[m_own];
                m_rnw = rr[m_own];
                m_wd = rw[m_own];
                lat = $urandom_range(0, 4);
                cnt = 0;
            end
            chk("rnd_busy", busy, m_busy);
            chk("rnd_de_req", de_req, m_busy);
            if (m_busy) begin
                chk("rnd_owner", owner, m_own);
                chk("rnd_addr", de_addr, m_addr);
                chk("rnd_nbyte", de_nbyte, m_nb);
                chk("rnd_rnw", de_rnw, m_rnw);
                chk("rnd_wdata", de_w_data, m_wd);
                dack = (cnt == lat);
                cnt++;
            end else begin
                dack = ($urandom_range(0, 7) == 0);
            end
            de_ack = dack;
            rd = $urandom;
            de_r_data = rd;
            #1;
            chk("rnd_ack0", ack0, m_busy & dack & ~m_own);
            chk("rnd_ack1", ack1, m_busy & dack & m_own);
            chk("rnd_rdata", rdata, rd);
            m_prev_ack = dack;
            for (int p = 0; p < 2; p++) begin
                if (hold[p]) begin
                    rq[p] = 0;
                    hold[p] = 0;
                end else if (pend[p]) begin
                    if (m_busy && dack && (m_own == p[0])) begin
                        pend[p] = 0;
                        hold[p] = 1;
                        n_xfer++;
                    end
                end else begin
                    ra[p] = AW'($urandom);
                    rn[p] = NW'($urandom);
                    rr[p] = 1'($urandom);
                    rw[p] = $urandom;
                    pend[p] = ($urandom_range(0, 2) == 0);
                    rq[p] = pend[p];
                end
            end
        end
        chk("rnd_enough_xfers", n_xfer > 100, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
